// File: rtl/aig_bist_pkg.sv
// Shared types, default sizes, polynomials and next-state helpers for the
// AIG BIST sequencer.
package aig_bist_pkg;

    localparam int N_IN_DEF  = 12;
    localparam int N_OUT_DEF = 16;

    // x^16 + x^12 + x^3 + x + 1
    localparam logic [15:0] MISR_POLY = 16'h100B;
    // Maximal-length 12-bit Galois taps
    localparam logic [11:0] LFSR_POLY = 12'hE08;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        WAIT,
        CAPTURE,
        DONE
    } state_t;

    // Galois right shift. Works for any width up to 32 as long as the
    // unused upper bits of v and poly are zero.
    function automatic logic [31:0] lfsr_next(input logic [31:0] v, input logic [31:0] poly);
        logic [31:0] shifted;
        shifted = v >> 1;
        return v[0] ? (shifted ^ poly) : shifted;
    endfunction

    // One MISR step of width w (1..32): shift left, fold the dropped MSB
    // back through the polynomial, then absorb the response.
    function automatic logic [31:0] misr_next(input logic [31:0] s, input logic [31:0] r,
                                              input logic [31:0] poly, input int w);
        logic [31:0] mask;
        logic [31:0] fb;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        fb   = (((s >> (w - 1)) & 32'd1) != 32'd0) ? poly : 32'd0;
        return (((s << 1) ^ fb) & mask) ^ r;
    endfunction

endpackage

// File: rtl/aig_bist_sequencer_if.sv
// Harness-side bus of the BIST sequencer: run control, netlist vector and
// response, and result reporting.
interface aig_bist_sequencer_if #(
    parameter int N_IN  = aig_bist_pkg::N_IN_DEF,
    parameter int N_OUT = aig_bist_pkg::N_OUT_DEF
);
    logic             start_i;
    logic             abort_i;
    logic             mode_i;
    logic [N_IN-1:0]  seed_i;
    logic [N_IN:0]    count_i;
    logic [N_OUT-1:0] golden_i;
    logic [N_IN-1:0]  vec_o;
    logic [N_OUT-1:0] resp_i;
    logic             busy_o;
    logic             done_o;
    logic             pass_o;
    logic [N_OUT-1:0] sig_o;
    logic [N_IN:0]    vec_cnt_o;

    // Harness plus netlist side
    modport master (
        output start_i, abort_i, mode_i, seed_i, count_i, golden_i, resp_i,
        input  vec_o, busy_o, done_o, pass_o, sig_o, vec_cnt_o
    );

    // Sequencer side
    modport slave (
        input  start_i, abort_i, mode_i, seed_i, count_i, golden_i, resp_i,
        output vec_o, busy_o, done_o, pass_o, sig_o, vec_cnt_o
    );
endinterface

// File: rtl/aig_bist_sequencer_misr.sv
// Multiple-input signature register compacting netlist responses.
module bist_misr #(
    parameter int               N_OUT = aig_bist_pkg::N_OUT_DEF,
    parameter logic [N_OUT-1:0] POLY  = aig_bist_pkg::MISR_POLY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [N_OUT-1:0] resp,
    output logic [N_OUT-1:0] sig
);
    import aig_bist_pkg::*;

    logic [N_OUT-1:0] sig_q;
    logic [N_OUT-1:0] sig_d;

    // Next signature: clear at run start, one compaction step per capture
    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = N_OUT'(misr_next(32'(sig_q), 32'(resp), 32'(POLY), N_OUT));
        end
    end

    // Signature register
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/aig_bist_sequencer.sv
// BIST sequencer for one combinational netlist: generates vectors
// (exhaustive counter or Galois LFSR), waits SETTLE cycles per vector,
// compacts responses in a MISR and compares against a golden signature.
module aig_bist_sequencer #(
    parameter int              N_IN      = aig_bist_pkg::N_IN_DEF,
    parameter int              N_OUT     = aig_bist_pkg::N_OUT_DEF,
    parameter int unsigned     SETTLE    = 1,
    parameter logic [N_OUT-1:0] MISR_POLY = aig_bist_pkg::MISR_POLY,
    parameter logic [N_IN-1:0]  LFSR_POLY = aig_bist_pkg::LFSR_POLY
) (
    input  logic                 clk,
    input  logic                 rst,
    aig_bist_sequencer_if.slave  bus
);
    import aig_bist_pkg::*;

    // Full vector space, also the saturation limit for the requested count
    localparam logic [N_IN:0] VEC_MAX   = {1'b1, {N_IN{1'b0}}};
    localparam logic [3:0]    WAIT_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    state_t           state_q, state_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic [N_IN:0]    cnt_q, cnt_d;
    logic [N_IN:0]    total_q, total_d;
    logic             mode_q, mode_d;
    logic [3:0]       wait_q, wait_d;
    logic             pass_q, pass_d;
    logic             misr_clr;
    logic             misr_en;
    logic [N_OUT-1:0] sig;
    logic             sig_match;

    assign sig_match = (sig == bus.golden_i);

    // Next-state, vector generation and run bookkeeping
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        total_d  = total_q;
        mode_d   = mode_q;
        wait_d   = wait_q;
        pass_d   = pass_q;
        misr_clr = 1'b0;
        misr_en  = 1'b0;

        case (state_q)
            IDLE: begin
                // A simultaneous abort suppresses the start
                if (bus.start_i && !bus.abort_i) begin
                    mode_d   = bus.mode_i;
                    misr_clr = 1'b1;
                    cnt_d    = '0;
                    pass_d   = 1'b0;
                    if (bus.mode_i) begin
                        // All-zero is the LFSR lock-up state, so nudge it to 1
                        vec_d = (bus.seed_i == '0) ? N_IN'(1) : bus.seed_i;
                        if (bus.count_i == '0) begin
                            total_d = (N_IN + 1)'(1);
                        end else if (bus.count_i > VEC_MAX) begin
                            total_d = VEC_MAX;
                        end else begin
                            total_d = bus.count_i;
                        end
                    end else begin
                        vec_d   = '0;
                        total_d = VEC_MAX;
                    end
                    state_d = APPLY;
                end
            end
            APPLY: begin
                wait_d  = '0;
                state_d = (SETTLE > 0) ? WAIT : CAPTURE;
            end
            WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = CAPTURE;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            CAPTURE: begin
                misr_en = 1'b1;
                cnt_d   = cnt_q + (N_IN + 1)'(1);
                // Finishing on the count keeps the counter from wrapping past all-ones
                if (cnt_q + (N_IN + 1)'(1) == total_q) begin
                    state_d = DONE;
                end else begin
                    if (mode_q) begin
                        vec_d = N_IN'(lfsr_next(32'(vec_q), 32'(LFSR_POLY)));
                    end else begin
                        vec_d = vec_q + N_IN'(1);
                    end
                    state_d = APPLY;
                end
            end
            DONE: begin
                pass_d  = sig_match;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort beats everything; signature and count stay frozen for debug
        if (bus.abort_i && (state_q != IDLE)) begin
            state_d = IDLE;
            pass_d  = 1'b0;
            misr_en = 1'b0;
            cnt_d   = cnt_q;
            vec_d   = vec_q;
        end
    end

    // Control and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            total_q <= '0;
            mode_q  <= 1'b0;
            wait_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
            mode_q  <= mode_d;
            wait_q  <= wait_d;
            pass_q  <= pass_d;
        end
    end

    bist_misr #(
        .N_OUT (N_OUT),
        .POLY  (MISR_POLY)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .clr  (misr_clr),
        .en   (misr_en),
        .resp (bus.resp_i),
        .sig  (sig)
    );

    assign bus.vec_o     = vec_q;
    assign bus.busy_o    = (state_q == APPLY) || (state_q == WAIT) || (state_q == CAPTURE);
    assign bus.done_o    = (state_q == DONE);
    // During DONE the live comparison is shown so pass is valid alongside done
    assign bus.pass_o    = (state_q == DONE) ? sig_match : pass_q;
    assign bus.sig_o     = sig;
    assign bus.vec_cnt_o = cnt_q;

endmodule

// File: tb/tb_aig_bist_sequencer.sv
// Directed bench: dut0 has SETTLE=0 with a scripted response, dut1 has
// SETTLE=1 and is driven by a small reference netlist model.
module tb_aig_bist_sequencer;

    typedef struct {
        int          cycles;
        logic [15:0] sig;
        logic        pass;
        logic [12:0] cnt;
        logic [11:0] last_vec;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        start_v, abort_v, mode_v;
    logic [11:0] seed_v;
    logic [12:0] count_v;
    logic [15:0] golden_v;
    logic        resp_sel0;
    logic [15:0] resp_c0;
    logic        use_model;

    logic [15:0] m_sig;
    logic [11:0] m_vec;
    logic [11:0] m_last;
    exp_t        e_tmp;
    int          n_done;

    always #5 clk = ~clk;

    function automatic logic [15:0] sw_misr(input logic [15:0] s, input logic [15:0] r);
        logic [15:0] t;
        t = {s[14:0], 1'b0};
        if (s[15]) t = t ^ 16'h100B;
        return t ^ r;
    endfunction

    function automatic logic [11:0] sw_lfsr(input logic [11:0] v);
        return v[0] ? ((v >> 1) ^ 12'hE08) : (v >> 1);
    endfunction

    // Stand-in for the netlist under test
    function automatic logic [15:0] net_model(input logic [11:0] v);
        return {v[3:0], v} ^ {v, v[11:8]} ^ {15'd0, ^v};
    endfunction

    aig_bist_sequencer_if #(.N_IN(12), .N_OUT(16)) if0 ();
    aig_bist_sequencer_if #(.N_IN(12), .N_OUT(16)) if1 ();

    assign if0.start_i  = start_v & ~sel;
    assign if1.start_i  = start_v & sel;
    assign if0.abort_i  = abort_v;
    assign if1.abort_i  = abort_v;
    assign if0.mode_i   = mode_v;
    assign if1.mode_i   = mode_v;
    assign if0.seed_i   = seed_v;
    assign if1.seed_i   = seed_v;
    assign if0.count_i  = count_v;
    assign if1.count_i  = count_v;
    assign if0.golden_i = golden_v;
    assign if1.golden_i = golden_v;
    assign if0.resp_i   = resp_sel0 ? ((if0.vec_o == 12'h001) ? 16'h8000 : 16'h0000) : resp_c0;
    assign if1.resp_i   = use_model ? net_model(if1.vec_o) : 16'h0000;

    aig_bist_sequencer #(.SETTLE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    aig_bist_sequencer #(.SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    wire [15:0] cur_sig  = sel ? if1.sig_o     : if0.sig_o;
    wire        cur_pass = sel ? if1.pass_o    : if0.pass_o;
    wire        cur_done = sel ? if1.done_o    : if0.done_o;
    wire        cur_busy = sel ? if1.busy_o    : if0.busy_o;
    wire [12:0] cur_cnt  = sel ? if1.vec_cnt_o : if0.vec_cnt_o;
    wire [11:0] cur_vec  = sel ? if1.vec_o     : if0.vec_o;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic m, input logic [11:0] s, input logic [12:0] c,
                            input logic [15:0] g);
        mode_v   = m;
        seed_v   = s;
        count_v  = c;
        golden_v = g;
        start_v  = 1'b1;
        @(posedge clk);
        #1 start_v = 1'b0;
    endtask

    // Waits for done on the selected DUT, measuring latency and how long
    // each vector stays on vec_o. cycles = -1 if the budget runs out.
    task automatic run_wait(input int budget, input int stable, output int cycles,
                            output logic [11:0] last_vec, output int bad_runs);
        logic [11:0] prev;
        int          run;
        bit          seen;
        cycles   = 0;
        bad_runs = 0;
        run      = 0;
        seen     = 1'b0;
        prev     = '0;
        last_vec = '0;
        while (cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (cur_done) begin
                seen = 1'b1;
                break;
            end
            if (cycles == 1) begin
                run = 1;
            end else if (cur_vec == prev) begin
                run++;
            end else begin
                if (run != stable) bad_runs++;
                run = 1;
            end
            prev     = cur_vec;
            last_vec = cur_vec;
        end
        if (!seen) cycles = -1;
        else if (run != stable) bad_runs++;
    endtask

    task automatic run_and_check(input string tag, input int budget, input int stable);
        exp_t        e;
        int          cyc;
        int          bad;
        logic [11:0] lv;
        e = sb.pop_front();
        run_wait(budget, stable, cyc, lv, bad);
        chk({tag, "_latency"}, cyc, e.cycles);
        chk({tag, "_sig"}, cur_sig, e.sig);
        chk({tag, "_pass"}, cur_pass, e.pass);
        chk({tag, "_cnt"}, cur_cnt, e.cnt);
        chk({tag, "_last_vec"}, lv, e.last_vec);
        chk({tag, "_vec_stable"}, bad, 0);
        chk({tag, "_busy_at_done"}, cur_busy, 1'b0);
        $display("run %s: %0d cycles sig=%h pass=%0d cnt=%0d", tag, cyc, cur_sig, cur_pass, cur_cnt);
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; start_v = 1'b0; abort_v = 1'b0; mode_v = 1'b0;
        seed_v = '0; count_v = '0; golden_v = '0; resp_sel0 = 1'b0; resp_c0 = '0; use_model = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_vec0", if0.vec_o, 0);      chk("rst_vec1", if1.vec_o, 0);
        chk("rst_busy0", if0.busy_o, 0);    chk("rst_busy1", if1.busy_o, 0);
        chk("rst_done0", if0.done_o, 0);    chk("rst_done1", if1.done_o, 0);
        chk("rst_pass0", if0.pass_o, 0);    chk("rst_pass1", if1.pass_o, 0);
        chk("rst_sig0", if0.sig_o, 0);      chk("rst_sig1", if1.sig_o, 0);
        chk("rst_cnt0", if0.vec_cnt_o, 0);  chk("rst_cnt1", if1.vec_cnt_o, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single LFSR vector, SETTLE=0
        resp_c0 = 16'h0001;
        e_tmp = '{cycles: 3, sig: 16'h0001, pass: 1'b1, cnt: 13'd1, last_vec: 12'h001};
        sb.push_back(e_tmp);
        do_start(1'b1, 12'h001, 13'd1, 16'h0001);
        run_and_check("t1_single", 20, 2);

        // Start during DONE is dropped; the following IDLE cycle accepts it
        start_v = 1'b1;
        @(posedge clk);
        #1 start_v = 1'b0;
        @(negedge clk);
        chk("done_start_ignored_busy", if0.busy_o, 1'b0);
        chk("pass_held", if0.pass_o, 1'b1);
        // Seed 0 maps to 1, count 0 runs one vector
        e_tmp = '{cycles: 3, sig: 16'h0001, pass: 1'b1, cnt: 13'd1, last_vec: 12'h001};
        sb.push_back(e_tmp);
        do_start(1'b1, 12'h000, 13'd0, 16'h0001);
        run_and_check("seed0_count0", 20, 2);

        // MISR feedback, stepwise
        @(negedge clk);
        resp_sel0 = 1'b1;
        do_start(1'b1, 12'h001, 13'd2, 16'h100B);
        @(negedge clk);
        chk("t2_pass_cleared", if0.pass_o, 1'b0);
        chk("t2_busy", if0.busy_o, 1'b1);
        chk("t2_vec1", if0.vec_o, 12'h001);
        @(negedge clk);
        @(negedge clk);
        chk("t2_sig1", if0.sig_o, 16'h8000);
        chk("t2_vec2", if0.vec_o, 12'hE08);
        chk("t2_cnt1", if0.vec_cnt_o, 13'd1);
        @(negedge clk);
        @(negedge clk);
        chk("t2_done", if0.done_o, 1'b1);
        chk("t2_sig2", if0.sig_o, 16'h100B);
        chk("t2_pass", if0.pass_o, 1'b1);
        $display("run t2_good: sig=%h pass=%0d", if0.sig_o, if0.pass_o);
        @(negedge clk);
        e_tmp = '{cycles: 5, sig: 16'h100B, pass: 1'b0, cnt: 13'd2, last_vec: 12'hE08};
        sb.push_back(e_tmp);
        do_start(1'b1, 12'h001, 13'd2, 16'h100A);
        run_and_check("t2_bad_golden", 20, 2);

        // Count above 4096 saturates
        @(negedge clk);
        resp_sel0 = 1'b0;
        resp_c0   = 16'h0000;
        m_vec = 12'h001;
        for (int i = 0; i < 4095; i++) m_vec = sw_lfsr(m_vec);
        e_tmp = '{cycles: 4096 * 2 + 1, sig: 16'h0000, pass: 1'b1, cnt: 13'd4096, last_vec: m_vec};
        sb.push_back(e_tmp);
        do_start(1'b1, 12'h001, 13'h1FFF, 16'h0000);
        run_and_check("saturate", 9000, 2);

        // Exhaustive runs on the SETTLE=1 instance
        sel = 1'b1;
        @(negedge clk);
        use_model = 1'b0;
        e_tmp = '{cycles: 4096 * 3 + 1, sig: 16'h0000, pass: 1'b1, cnt: 13'd4096, last_vec: 12'hFFF};
        sb.push_back(e_tmp);
        do_start(1'b0, 12'h000, 13'd0, 16'h0000);
        run_and_check("exh_zero", 13000, 3);

        @(negedge clk);
        use_model = 1'b1;
        m_sig = '0;
        for (int v = 0; v < 4096; v++) m_sig = sw_misr(m_sig, net_model(12'(v)));
        e_tmp = '{cycles: 4096 * 3 + 1, sig: m_sig, pass: 1'b1, cnt: 13'd4096, last_vec: 12'hFFF};
        sb.push_back(e_tmp);
        do_start(1'b0, 12'h000, 13'd0, m_sig);
        run_and_check("exh_model", 13000, 3);

        // Abort at vector 100, with a stray start mid-run
        @(negedge clk);
        do_start(1'b0, 12'h000, 13'd0, 16'h0000);
        repeat (150) @(negedge clk);
        mode_v  = 1'b1;
        seed_v  = 12'h777;
        start_v = 1'b1;
        @(posedge clk);
        #1 start_v = 1'b0;
        mode_v = 1'b0;
        repeat (151) @(negedge clk);
        chk("busy_start_no_restart_vec", if1.vec_o, 12'd100);
        chk("abort_pre_cnt", if1.vec_cnt_o, 13'd100);
        chk("abort_pre_busy", if1.busy_o, 1'b1);
        abort_v = 1'b1;
        @(negedge clk);
        abort_v = 1'b0;
        m_sig = '0;
        for (int v = 0; v < 100; v++) m_sig = sw_misr(m_sig, net_model(12'(v)));
        chk("abort_busy", if1.busy_o, 1'b0);
        chk("abort_done", if1.done_o, 1'b0);
        chk("abort_cnt", if1.vec_cnt_o, 13'd100);
        chk("abort_pass", if1.pass_o, 1'b0);
        chk("abort_sig", if1.sig_o, m_sig);
        n_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (if1.done_o) n_done++;
        end
        chk("abort_no_done", n_done, 0);
        $display("run abort: cnt=%0d sig=%h", if1.vec_cnt_o, if1.sig_o);

        // Reset at vector 50
        do_start(1'b0, 12'h000, 13'd0, 16'h0000);
        repeat (151) @(negedge clk);
        chk("rst_pre_cnt", if1.vec_cnt_o, 13'd50);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_vec", if1.vec_o, 0);
        chk("midrst_busy", if1.busy_o, 0);
        chk("midrst_done", if1.done_o, 0);
        chk("midrst_pass", if1.pass_o, 0);
        chk("midrst_sig", if1.sig_o, 0);
        chk("midrst_cnt", if1.vec_cnt_o, 0);
        $display("run midrst: outputs cleared");

        // Clean LFSR run after reset
        m_sig = '0;
        m_vec = 12'h5A5;
        m_last = '0;
        for (int i = 0; i < 5; i++) begin
            m_sig  = sw_misr(m_sig, net_model(m_vec));
            m_last = m_vec;
            m_vec  = sw_lfsr(m_vec);
        end
        e_tmp = '{cycles: 5 * 3 + 1, sig: m_sig, pass: 1'b1, cnt: 13'd5, last_vec: m_last};
        sb.push_back(e_tmp);
        do_start(1'b1, 12'h5A5, 13'd5, m_sig);
        run_and_check("post_rst_lfsr", 100, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
